// File: rtl/hi_tag_modulator_pkg.sv
// Shared HF FPGA constants for the tag simulator and the reader-side blocks.
// Contents: subcarrier select codes, tag-sim minor mode codes and the
// subcarrier decode helper used by the tag modulator.
package hi_tag_modulator_pkg;

  localparam logic [1:0] FPGA_HF_READER_SUBCARRIER_848_KHZ = 2'b00;
  localparam logic [1:0] FPGA_HF_READER_SUBCARRIER_424_KHZ = 2'b01;
  localparam logic [1:0] FPGA_HF_READER_SUBCARRIER_212_KHZ = 2'b10;

  localparam logic [2:0] FPGA_HF_TAGSIM_MODE_LISTEN         = 3'b000;
  localparam logic [2:0] FPGA_HF_TAGSIM_MODE_MOD_OOK        = 3'b001;
  localparam logic [2:0] FPGA_HF_TAGSIM_MODE_MOD_BPSK       = 3'b010;
  localparam logic [2:0] FPGA_HF_TAGSIM_MODE_MOD_MANCHESTER = 3'b011;

  // Subcarrier level from ETU counter bits [5:3]. The subcarrier is high in
  // the first half of each of its periods, so every ETU starts on a period
  // boundary. The unused code 2'b11 falls back to 424 kHz.
  function automatic logic subcarrier(input logic [1:0] freq, input logic [2:0] cnt_hi);
    logic sc;
    case (freq)
      FPGA_HF_READER_SUBCARRIER_848_KHZ: sc = ~cnt_hi[0];
      FPGA_HF_READER_SUBCARRIER_212_KHZ: sc = ~cnt_hi[2];
      default:                           sc = ~cnt_hi[1];
    endcase
    return sc;
  endfunction

endpackage

// File: rtl/hf_hysteresis_detect.sv
// Reader field modulation detector with hysteresis.
// Ports:
//   ck_1356meg in  carrier clock, state updates on the falling edge
//   rst_n      in  asynchronous active-low reset
//   adc_d      in  8-bit ADC sample
//   state      out detector state: full-scale sets, zero clears, and a
//                  LOW_TIMEOUT-clock low run forces it back high
module hf_hysteresis_detect
  import hi_tag_modulator_pkg::*;
#(
  parameter int LOW_TIMEOUT = 4095
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic [7:0] adc_d,
  output logic       state
);

  localparam int              CNT_W    = $clog2(LOW_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOW_TIMEOUT - 1);

  logic             state_r;
  logic [CNT_W-1:0] low_cnt_r;
  logic             timeout_s;

  // The clock that completes LOW_TIMEOUT clocks of low state forces it high.
  always_comb begin
    timeout_s = 1'b0;
    if (!state_r && (low_cnt_r == CNT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Detector state and low-run counter.
  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= 1'b0;
      low_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (adc_d == 8'hFF) begin
        state_r <= 1'b1;
      end else if (timeout_s) begin
        state_r <= 1'b1;
      end else if (adc_d == 8'h00) begin
        state_r <= 1'b0;
      end else begin
        state_r <= state_r;
      end
      if (state_r || timeout_s) begin
        low_cnt_r <= {CNT_W{1'b0}};
      end else begin
        low_cnt_r <= low_cnt_r + 1'b1;
      end
    end
  end

  assign state = state_r;

endmodule

// File: rtl/hi_tag_modulator.sv
// HF tag simulator: load-modulates the antenna with an OOK, BPSK or
// Manchester subcarrier carrying bits received from the ARM over SSP, and
// returns the reader-field detector state over the same link.
// Ports:
//   ck_1356meg in  13.56 MHz carrier, all state changes on its falling edge
//   rst_n      in  asynchronous active-low reset
//   adc_d      in  ADC sample feeding the field detector
//   adc_clk    out carrier clock passed through to the ADC
//   ssp_dout   in  next transmit bit from the ARM
//   ssp_clk    out SSP bit clock, high in the first half of each ETU
//   ssp_frame  out high for the whole ETU in which bit_cnt is 0
//   ssp_din    out field detector state captured at each ETU boundary
//   pwr_*      out antenna drivers; only oe1/oe2/oe4 ever toggle
//   dbg        out registered modulation
//   subcarrier_frequency in subcarrier select
//   minor_mode in  operating mode
module hi_tag_modulator
  import hi_tag_modulator_pkg::*;
#(
  parameter int ETU_LOG2    = 7,
  parameter int LOW_TIMEOUT = 4095
) (
  input  logic       ck_1356meg,
  input  logic       rst_n,
  input  logic [7:0] adc_d,
  output logic       adc_clk,
  input  logic       ssp_dout,
  output logic       ssp_clk,
  output logic       ssp_frame,
  output logic       ssp_din,
  output logic       pwr_lo,
  output logic       pwr_hi,
  output logic       pwr_oe1,
  output logic       pwr_oe2,
  output logic       pwr_oe3,
  output logic       pwr_oe4,
  output logic       dbg,
  input  logic [1:0] subcarrier_frequency,
  input  logic [2:0] minor_mode
);

  localparam logic [ETU_LOG2-1:0] ETU_LAST = {ETU_LOG2{1'b1}};
  localparam logic [ETU_LOG2-1:0] ETU_HALF = {1'b1, {(ETU_LOG2-1){1'b0}}};

  logic [2:0]          mode_r;
  logic [ETU_LOG2-1:0] etu_cnt_r;
  logic [2:0]          bit_cnt_r;
  logic                next_bit_r;
  logic                tx_bit_r;
  logic                mod_r;
  logic                ssp_clk_r;
  logic                ssp_frame_r;
  logic                ssp_din_r;
  logic                hyst_state_s;

  logic                mode_change_s;
  logic                etu_wrap_s;
  logic                sc_s;
  logic                first_half_s;
  logic                mod_s;
  logic [ETU_LOG2-1:0] etu_next_s;
  logic [2:0]          bit_next_s;

  hf_hysteresis_detect #(
    .LOW_TIMEOUT (LOW_TIMEOUT)
  ) u_hyst (
    .ck_1356meg (ck_1356meg),
    .rst_n      (rst_n),
    .adc_d      (adc_d),
    .state      (hyst_state_s)
  );

  // Raw modulation and next counter values; a mode change restarts the ETU.
  always_comb begin
    mode_change_s = (minor_mode != mode_r);
    etu_wrap_s    = (etu_cnt_r == ETU_LAST);
    sc_s          = subcarrier(subcarrier_frequency, etu_cnt_r[5:3]);
    first_half_s  = ~etu_cnt_r[ETU_LOG2-1];
    mod_s         = 1'b0;
    case (mode_r)
      FPGA_HF_TAGSIM_MODE_MOD_OOK:        mod_s = tx_bit_r & sc_s;
      FPGA_HF_TAGSIM_MODE_MOD_BPSK:       mod_s = sc_s ^ tx_bit_r;
      FPGA_HF_TAGSIM_MODE_MOD_MANCHESTER: mod_s = sc_s & (tx_bit_r ? first_half_s : ~first_half_s);
      default:                            mod_s = 1'b0;
    endcase
    if (mode_change_s) begin
      etu_next_s = {ETU_LOG2{1'b0}};
      bit_next_s = 3'd0;
    end else begin
      etu_next_s = etu_cnt_r + 1'b1;
      bit_next_s = etu_wrap_s ? (bit_cnt_r + 3'd1) : bit_cnt_r;
    end
  end

  // Counters, transmit bit pipeline and registered outputs. SSP clock/frame
  // are decoded from the next counter values so they line up with etu_cnt.
  always_ff @(negedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      mode_r      <= FPGA_HF_TAGSIM_MODE_LISTEN;
      etu_cnt_r   <= {ETU_LOG2{1'b0}};
      bit_cnt_r   <= 3'd0;
      next_bit_r  <= 1'b0;
      tx_bit_r    <= 1'b0;
      mod_r       <= 1'b0;
      ssp_clk_r   <= 1'b0;
      ssp_frame_r <= 1'b0;
      ssp_din_r   <= 1'b0;
    end else begin
      mode_r      <= minor_mode;
      etu_cnt_r   <= etu_next_s;
      bit_cnt_r   <= bit_next_s;
      ssp_clk_r   <= ~etu_next_s[ETU_LOG2-1];
      ssp_frame_r <= (bit_next_s == 3'd0);
      if (mode_change_s) begin
        // Restart wins over a coinciding ETU boundary: nothing is loaded.
        next_bit_r <= 1'b0;
        tx_bit_r   <= 1'b0;
        mod_r      <= 1'b0;
        ssp_din_r  <= ssp_din_r;
      end else begin
        mod_r <= mod_s;
        if (etu_cnt_r == ETU_HALF) begin
          next_bit_r <= ssp_dout;
        end else begin
          next_bit_r <= next_bit_r;
        end
        if (etu_wrap_s) begin
          tx_bit_r  <= next_bit_r;
          ssp_din_r <= hyst_state_s;
        end else begin
          tx_bit_r  <= tx_bit_r;
          ssp_din_r <= ssp_din_r;
        end
      end
    end
  end

  assign adc_clk   = ck_1356meg;
  assign ssp_clk   = ssp_clk_r;
  assign ssp_frame = ssp_frame_r;
  assign ssp_din   = ssp_din_r;
  assign pwr_oe1   = mod_r;
  assign pwr_oe2   = mod_r;
  assign pwr_oe4   = mod_r;
  assign dbg       = mod_r;
  assign pwr_hi    = 1'b0;
  assign pwr_lo    = 1'b0;
  assign pwr_oe3   = 1'b0;

endmodule
